reg_writeback_queue: RTL and testbench

Write-side companion to the register file: collects register write requests from two producers (single-cycle ALU result path and multi-cycle mult/div unit), buffers them in order in a small FIFO, and drains one entry per cycle onto the register file's single write port (`regWrite`/`writeReg`/`writeData`). It also gives decode-stage readers a forwarding lookup, so a value still pending in the queue is visible before it reaches the register file.

---
 rtl/reg_writeback_queue.sv | 126 ++++++++++++
 tb/tb_reg_writeback_queue.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// Ordered write-back queue in front of the register file: two producers (ALU with
// priority over mult/div) push, one entry drains per cycle, and pending values are forwarded.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     aluValid,
  input  logic [ADDR_W-1:0]        aluReg,
  input  logic [DATA_W-1:0]        aluData,
  output logic                     aluReady,
  input  logic                     mduValid,
  input  logic [ADDR_W-1:0]        mduReg,
  input  logic [DATA_W-1:0]        mduData,
  output logic                     mduReady,
  input  logic                     drainEn,
  output logic                     regWrite,
  output logic [ADDR_W-1:0]        writeReg,
  output logic [DATA_W-1:0]        writeData,
  input  logic [ADDR_W-1:0]        fwdReg1,
  input  logic [ADDR_W-1:0]        fwdReg2,
  output logic                     fwdHit1,
  output logic                     fwdHit2,
  output logic [DATA_W-1:0]        fwdData1,
  output logic [DATA_W-1:0]        fwdData2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  logic [ADDR_W-1:0] r_reg  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  ptr_t              r_head;
  ptr_t              r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_space;
  logic              w_alu_fire;
  logic              w_mdu_fire;
  logic              w_push;
  logic [ADDR_W-1:0] w_push_reg;
  logic [DATA_W-1:0] w_push_data;
  ptr_t              w_idx;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Reset gates every handshake so nothing transfers or drains in a reset cycle.
  assign w_pop   = reset & drainEn & ~w_empty;
  assign w_space = reset & (~w_full | w_pop);

  assign aluReady = w_space;
  assign mduReady = w_space & ~aluValid;

  assign w_alu_fire  = aluValid & w_space;
  assign w_mdu_fire  = mduValid & w_space & ~aluValid;
  assign w_push_reg  = w_alu_fire ? aluReg  : mduReg;
  assign w_push_data = w_alu_fire ? aluData : mduData;
  // Writes to register 0 complete the handshake but are never stored.
  assign w_push      = (w_alu_fire | w_mdu_fire) & (w_push_reg != '0);

  assign regWrite  = w_pop;
  assign writeReg  = w_empty ? '0 : r_reg[r_head];
  assign writeData = w_empty ? '0 : r_data[r_head];

  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)  r_head <= r_head + ptr_t'(1);
      if (w_push) r_tail <= r_tail + ptr_t'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the entry array is deliberately left out of reset; count gates every read of it.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_reg[r_tail]  <= w_push_reg;
      r_data[r_tail] <= w_push_data;
    end
  end

  // Walk from head to tail so a later (younger) match overrides an older one.
  always_comb begin
    fwdHit1  = 1'b0;
    fwdHit2  = 1'b0;
    fwdData1 = '0;
    fwdData2 = '0;
    w_idx    = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + ptr_t'(i);
      if (CNT_W'(i) < r_count) begin
        if (fwdReg1 != '0 && r_reg[w_idx] == fwdReg1) begin
          fwdHit1  = 1'b1;
          fwdData1 = r_data[w_idx];
        end
        if (fwdReg2 != '0 && r_reg[w_idx] == fwdReg2) begin
          fwdHit2  = 1'b1;
          fwdData2 = r_data[w_idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: directed scenarios plus random traffic,
// checked against a queue model; a separate monitor scores every register-file write.
module tb_reg_writeback_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              aluValid = 1'b0, mduValid = 1'b0, drainEn = 1'b0;
  logic [ADDR_W-1:0] aluReg = '0, mduReg = '0, fwdReg1 = '0, fwdReg2 = '0;
  logic [DATA_W-1:0] aluData = '0, mduData = '0;
  logic              aluReady, mduReady, regWrite, fwdHit1, fwdHit2, full, empty;
  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData, fwdData1, fwdData2;
  logic [CNT_W-1:0]  count;

  always #5 clock = ~clock;

  reg_writeback_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .aluValid(aluValid), .aluReg(aluReg), .aluData(aluData), .aluReady(aluReady),
    .mduValid(mduValid), .mduReg(mduReg), .mduData(mduData), .mduReady(mduReady),
    .drainEn(drainEn), .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
    .fwdReg1(fwdReg1), .fwdReg2(fwdReg2), .fwdHit1(fwdHit1), .fwdHit2(fwdHit2),
    .fwdData1(fwdData1), .fwdData2(fwdData2), .count(count), .full(full), .empty(empty)
  );

  typedef struct {
    logic [ADDR_W-1:0] r;
    logic [DATA_W-1:0] d;
  } ent_t;

  ent_t mq[$];   // reference model contents, oldest first
  ent_t sb[$];   // expected register-file writes, in order
  ent_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   last_alu_fire = 1'b0;
  bit   last_mdu_fire = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_fwd(input logic [ADDR_W-1:0] r, output logic hit,
                                    output logic [DATA_W-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (r != '0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].r == r) begin
          hit = 1'b1;
          d   = mq[i].d;
          break;
        end
      end
    end
  endfunction

  // Monitor: every write the DUT issues must be the next expected one.
  initial begin
    forever begin
      @(negedge clock);
      if (regWrite === 1'b1) begin
        if (!reset) check("wr_during_reset", regWrite, 0);
        else if (sb.size() == 0) check("wr_unexpected", regWrite, 0);
        else begin
          mon_e = sb.pop_front();
          check("wr_reg", writeReg, mon_e.r);
          check("wr_data", writeData, mon_e.d);
        end
      end
    end
  end

  // Mid-cycle comparison of every combinational output against the model.
  task automatic at_neg();
    bit pop, space, h;
    logic [DATA_W-1:0] d;
    @(negedge clock);
    pop   = reset && drainEn && mq.size() > 0;
    space = reset && (mq.size() < DEPTH || pop);
    check("aluReady", aluReady, space);
    check("mduReady", mduReady, space && !aluValid);
    check("regWrite", regWrite, pop);
    check("count", count, mq.size());
    check("full", full, mq.size() == DEPTH);
    check("empty", empty, mq.size() == 0);
    check("writeReg", writeReg, mq.size() > 0 ? mq[0].r : '0);
    check("writeData", writeData, mq.size() > 0 ? mq[0].d : '0);
    model_fwd(fwdReg1, h, d);
    check("fwdHit1", fwdHit1, h);
    check("fwdData1", fwdData1, d);
    model_fwd(fwdReg2, h, d);
    check("fwdHit2", fwdHit2, h);
    check("fwdData2", fwdData2, d);
  endtask

  task automatic tick();
    bit pop, space, af, mf;
    pop   = reset && drainEn && mq.size() > 0;
    space = reset && (mq.size() < DEPTH || pop);
    af    = aluValid && space;
    mf    = mduValid && space && !aluValid;
    @(posedge clock);
    if (!reset) begin
      mq.delete();
      sb.delete();
    end else begin
      if (pop) void'(mq.pop_front());
      if (af && aluReg != '0) begin
        mq.push_back('{aluReg, aluData});
        sb.push_back('{aluReg, aluData});
      end else if (mf && mduReg != '0) begin
        mq.push_back('{mduReg, mduData});
        sb.push_back('{mduReg, mduData});
      end
    end
    last_alu_fire = af;
    last_mdu_fire = mf;
    #1;
  endtask

  task automatic cyc();
    at_neg();
    tick();
  endtask

  task automatic idle(input logic drain);
    aluValid = 1'b0;
    mduValid = 1'b0;
    drainEn  = drain;
  endtask

  task automatic alu(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d, input logic drain);
    aluValid = 1'b1; aluReg = r; aluData = d;
    mduValid = 1'b0; drainEn = drain;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int order [4] = '{2, 3, 4, 6};

    // Reset held low for two cycles, then the reset-state outputs.
    reset = 1'b0;
    idle(1'b1);
    @(posedge clock); #1;
    alu(5'd9, 32'h99, 1'b1);
    cyc();
    cyc();
    reset = 1'b1;
    idle(1'b0);
    at_neg();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_fwdHit1", fwdHit1, 0);
    tick();

    // Single push, forward, then drain.
    alu(5'd5, 32'h1234, 1'b0);
    cyc();
    idle(1'b0);
    fwdReg1 = 5'd5;
    at_neg();
    check("single_count", count, 1);
    check("single_fwd", fwdData1, 32'h1234);
    tick();
    idle(1'b1);
    at_neg();
    check("single_wr", regWrite, 1);
    check("single_wr_reg", writeReg, 5);
    check("single_popfwd", fwdHit1, 1);
    tick();
    at_neg();
    check("single_once", regWrite, 0);
    check("single_empty", empty, 1);
    tick();

    // Arbitration: ALU wins, MDU held and accepted next cycle.
    alu(5'd3, 32'hA, 1'b0);
    mduValid = 1'b1; mduReg = 5'd4; mduData = 32'hB;
    at_neg();
    check("arb_alu_rdy", aluReady, 1);
    check("arb_mdu_rdy", mduReady, 0);
    tick();
    aluValid = 1'b0;
    at_neg();
    check("arb_mdu_rdy2", mduReady, 1);
    tick();
    idle(1'b1);
    at_neg();
    check("arb_first", writeReg, 3);
    tick();
    at_neg();
    check("arb_second", writeReg, 4);
    tick();

    // Full boundary and pointer wrap.
    for (int r = 1; r <= 4; r++) begin
      alu(ADDR_W'(r), 32'h100 + r, 1'b0);
      cyc();
    end
    alu(5'd6, 32'h66, 1'b0);
    at_neg();
    check("full_flag", full, 1);
    check("full_alu_rdy", aluReady, 0);
    check("full_mdu_rdy", mduReady, 0);
    tick();
    drainEn = 1'b1;
    at_neg();
    check("full_pp_rdy", aluReady, 1);
    check("full_pp_wreg", writeReg, 1);
    tick();
    idle(1'b0);
    at_neg();
    check("full_pp_count", count, 4);
    tick();
    idle(1'b1);
    for (int i = 0; i < 4; i++) begin
      at_neg();
      check("full_order", writeReg, order[i]);
      tick();
    end

    // Youngest-match forwarding.
    fwdReg2 = 5'd7;
    alu(5'd7, 32'h11, 1'b0);
    cyc();
    alu(5'd7, 32'h22, 1'b0);
    cyc();
    idle(1'b1);
    at_neg();
    check("young_fwd0", fwdData2, 32'h22);
    tick();
    at_neg();
    check("young_fwd1", fwdData2, 32'h22);
    tick();
    at_neg();
    check("young_hit2", fwdHit2, 0);
    tick();

    // Register 0 is accepted but dropped.
    fwdReg1 = 5'd0;
    alu(5'd0, 32'hFFFF, 1'b1);
    at_neg();
    check("r0_ready", aluReady, 1);
    tick();
    idle(1'b1);
    at_neg();
    check("r0_count", count, 0);
    check("r0_nowr", regWrite, 0);
    check("r0_hit", fwdHit1, 0);
    tick();

    // Reset with three entries pending.
    for (int r = 9; r <= 11; r++) begin
      alu(ADDR_W'(r), 32'hC00 + r, 1'b0);
      cyc();
    end
    reset = 1'b0;
    idle(1'b1);
    at_neg();
    check("rstmid_nowr", regWrite, 0);
    tick();
    reset = 1'b1;
    at_neg();
    check("rstmid_count", count, 0);
    check("rstmid_empty", empty, 1);
    tick();
    for (int i = 0; i < 3; i++) cyc();

    // Random traffic with producers honouring the hold rule.
    for (int n = 0; n < 1500; n++) begin
      if (!aluValid || last_alu_fire) begin
        aluValid = ($urandom_range(0, 99) < 45);
        aluReg   = ADDR_W'($urandom_range(0, 7));
        aluData  = $urandom;
      end
      if (!mduValid || last_mdu_fire) begin
        mduValid = ($urandom_range(0, 99) < 40);
        mduReg   = ADDR_W'($urandom_range(0, 7));
        mduData  = $urandom;
      end
      drainEn = ($urandom_range(0, 99) < 60);
      fwdReg1 = ADDR_W'($urandom_range(0, 7));
      fwdReg2 = ADDR_W'($urandom_range(0, 7));
      reset   = ($urandom_range(0, 299) != 0);
      cyc();
    end

    // Final drain: every expected write must have appeared.
    reset = 1'b1;
    idle(1'b1);
    for (int i = 0; i < DEPTH + 2; i++) cyc();
    check("sb_drained", sb.size(), 0);
    check("end_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
